// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial packed-BCD add/subtract sequencer.
//   bcd_seq_state_t : sequencer state encoding (IDLE, RUN, DONE)
//   BCD_DIGIT_W     : bits per BCD digit
//   bcd_nines()     : nines complement of one digit (9-d)
//   bcd_digit_ok()  : 1 when a nibble is a legal decimal digit (0..9)
package bcd_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} bcd_seq_state_t;

  localparam int BCD_DIGIT_W = 4;

  function automatic logic [BCD_DIGIT_W-1:0] bcd_nines(input logic [BCD_DIGIT_W-1:0] d);
    return 4'd9 - d;
  endfunction

  function automatic logic bcd_digit_ok(input logic [BCD_DIGIT_W-1:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_adder.sv
// Two-digit (one byte) packed-BCD adder with carry in/out.
//   i_a, i_b : 8-bit packed BCD operands, digit 0 in [3:0]
//   i_cin    : decimal carry in
//   o_s      : 8-bit packed BCD sum
//   o_cout   : decimal carry out
// Operands are assumed to be legal BCD; illegal digits give undefined digits.
module bcd_adder
  import bcd_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_s,
  output logic       o_cout
);

  logic [4:0] w_raw_lo;
  logic [4:0] w_raw_hi;
  logic [4:0] w_adj_lo;
  logic [4:0] w_adj_hi;
  logic       w_c_mid;

  // Binary digit sum; anything above 9 is corrected by +6, which also
  // pushes the excess out as the decimal carry.
  always_comb begin
    w_raw_lo = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0, i_cin};
    w_c_mid  = (w_raw_lo > 5'd9);
    w_adj_lo = w_c_mid ? (w_raw_lo + 5'd6) : w_raw_lo;

    w_raw_hi = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + {4'b0, w_c_mid};
    o_cout   = (w_raw_hi > 5'd9);
    w_adj_hi = o_cout ? (w_raw_hi + 5'd6) : w_raw_hi;

    o_s = {w_adj_hi[BCD_DIGIT_W-1:0], w_adj_lo[BCD_DIGIT_W-1:0]};
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD add/subtract sequencer. One shared bcd_adder processes
// one byte (two digits) per cycle, LSB byte first, chaining the carry.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : command handshake (in_a, in_b, in_sub)
//   in_sub               : 0 = A+B, 1 = A-B (nines complement of B plus carry-in 1)
//   out_valid/out_ready  : result handshake (out_sum, out_carry, out_err)
//   out_carry            : add = decimal overflow, sub = borrow (A<B)
//   out_err              : some input nibble was > 9; sum/carry forced to 0
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid only in DONE, and both
// are pure functions of state, so neither depends combinationally on the
// other side's valid/ready. Results are held stable while out_ready is low.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_a,
  input  logic [4*NUM_DIGITS-1:0] in_b,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_sum,
  output logic                    out_carry,
  output logic                    out_err
);

  localparam int NBYTES = NUM_DIGITS / 2;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  if (((NUM_DIGITS % 2) != 0) || (NUM_DIGITS < 2)) begin : g_bad_param
    $error("bcd_serial_add_ctrl: NUM_DIGITS must be even and >= 2");
  end

  bcd_seq_state_t r_state;
  bcd_seq_state_t w_state_next;

  logic [NBYTES-1:0][7:0] r_a;
  logic [NBYTES-1:0][7:0] r_b;
  logic [NBYTES-1:0][7:0] r_sum;
  logic [NBYTES-1:0][7:0] w_sum_next;
  logic                   r_sub;
  logic                   r_carry;
  logic                   r_err;
  logic [IDX_W-1:0]       r_idx;

  logic [4*NUM_DIGITS-1:0] r_out_sum;
  logic                    r_out_carry;
  logic                    r_out_err;

  logic [4*NUM_DIGITS-1:0] w_b_nines;
  logic                    w_in_err;
  logic                    w_accept;
  logic                    w_last;
  logic [7:0]              w_s;
  logic                    w_cout;

  bcd_adder u_adder (
    .i_a    (r_a[r_idx]),
    .i_b    (r_b[r_idx]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // Operand conditioning at accept time.
  always_comb begin
    w_b_nines = '0;
    w_in_err  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_b_nines[i*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_nines(in_b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
      if (!bcd_digit_ok(in_a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          !bcd_digit_ok(in_b[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
        w_in_err = 1'b1;
      end
    end
  end

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

  // Working result with this pass's byte merged in; on the last pass this
  // is the complete result.
  always_comb begin
    w_sum_next        = r_sum;
    w_sum_next[r_idx] = w_s;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_out_sum   <= '0;
      r_out_carry <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= in_sub ? w_b_nines : in_b;
        r_sub   <= in_sub;
        r_carry <= in_sub;  // +1 turns the nines complement into tens complement
        r_err   <= w_in_err;
        r_idx   <= '0;
        r_sum   <= '0;
      end else if (r_state == RUN) begin
        r_sum   <= w_sum_next;
        r_carry <= w_cout;
        if (!w_last) r_idx <= r_idx + 1'b1;
      end

      // Presented outputs change only when a new result is produced, so
      // they hold through DONE and keep their values afterwards.
      if (w_last) begin
        r_out_sum   <= r_err ? '0 : w_sum_next;
        r_out_carry <= r_err ? 1'b0 : (r_sub ? ~w_cout : w_cout);
        r_out_err   <= r_err;
      end
    end
  end

  assign out_sum   = r_out_sum;
  assign out_carry = r_out_carry;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
module tb_bcd_serial_add_ctrl;

  localparam int ND = 8;
  localparam int W  = 4 * ND;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_err;

  int checks;
  int failures;

  // {err, carry, sum}
  logic [W+1:0] exp_q[$];

  bcd_serial_add_ctrl #(.NUM_DIGITS(ND)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_err   (out_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one command at a negedge; accepted on the following posedge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(negedge clk);
    check("send_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, checking latency and result, then consume.
  task automatic collect(input string tag);
    int n;
    logic [W+1:0] e;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n = i;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 64'(n), 64'd5);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_sum"},   64'(out_sum),   64'(e[W-1:0]));
      check({tag, "_carry"}, 64'(out_carry), 64'(e[W]));
      check({tag, "_err"},   64'(out_err),   64'(e[W+1]));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready),  64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] es, input logic ec, input logic ee);
    exp_q.push_back({ee, ec, es});
    send(a, b, sub);
    collect(tag);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_carry", 64'(out_carry), 64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);

    run_op("add_basic",  32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);
    run_op("add_ripple", 32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("sub_pos",    32'h00000100, 32'h00000001, 1'b1, 32'h00000099, 1'b0, 1'b0);
    run_op("sub_borrow", 32'h00000000, 32'h00000001, 1'b1, 32'h99999999, 1'b1, 1'b0);
    run_op("add_err",    32'h0000000A, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1);
    run_op("sub_mixed",  32'h50000000, 32'h00000001, 1'b1, 32'h49999999, 1'b0, 1'b0);

    // Backpressure with in_valid held high throughout.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'h00000011;
    in_b     = 32'h00000022;
    in_sub   = 1'b0;
    @(posedge clk);
    #1;
    in_a = 32'h00000002;
    in_b = 32'h00000003;
    exp_q.push_back({1'b0, 1'b0, 32'h00000005});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_sum",   64'(out_sum),   64'h00000033);
    held_sum = out_sum;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_sum",   64'(out_sum),   64'h00000033);
      check("bp_hold_carry", 64'(out_carry), 64'd0);
      check("bp_hold_ready", 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready),  64'd1);
    check("bp_sum_kept",      64'(out_sum),   64'(held_sum));
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_second_accept", 64'(in_ready), 64'd0);
    collect("bp_second");

    // Reset during the second RUN cycle.
    send(32'h12345678, 32'h87654321, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    repeat (6) @(negedge clk);
    check("midrst_no_result", 64'(out_valid), 64'd0);
    run_op("post_rst_add", 32'h00000005, 32'h00000005, 1'b0, 32'h00000010, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

endmodule
